// File: rtl/regdump_pkg.sv
// regdump_pkg: shared definitions for the register-file dump engine.
//   state_t  - dump FSM states (IDLE, READ, HOLD)
//   DW_DEF   - default register data width
//   AW_DEF   - default register address width
//   NREGS    - number of architectural registers
package regdump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NREGS  = 32;

endpackage

// File: rtl/regdump.sv
// regdump: walks a range of register-file entries through a combinational
// read port and presents each value on a valid/ready stream.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start                 one-cycle dump request (honoured in IDLE only)
//   first_addr, last_addr dump range, sampled with start; range may wrap
//   ra / rd               register-file read address / combinational data
//   we3, wa3, wd3         snooped register-file write port
//   dout_valid/ready      output handshake
//   dout_data/addr/last   register value, its index, final-word flag
//   busy                  FSM not in IDLE
//   done                  one-cycle pulse after the final word is accepted
//
// Build option
//   REGDUMP_FWD_EN  when defined, a write to the register being read in the
//                   same cycle is forwarded into dout_data (register 0 is
//                   never forwarded). When undefined the write port is ignored.
module regdump
  import regdump_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [DW-1:0] wd3,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic [AW-1:0] dout_addr,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nx;
  logic [AW-1:0] cnt;
  logic [AW-1:0] last_q;
  logic          hs;
  logic          at_last;
  logic [DW-1:0] cap_data;

  assign at_last = (cnt == last_q);
  assign hs      = (state == HOLD) && dout_ready;

`ifdef REGDUMP_FWD_EN
  // A write landing on the register being read this cycle wins over the
  // stale read data; register 0 is hardwired and never forwarded.
  assign cap_data = (we3 && (wa3 == ra) && (ra != '0)) ? wd3 : rd;
`else
  logic unused_snoop;
  assign unused_snoop = &{1'b0, we3, wa3, wd3};
  assign cap_data     = rd;
`endif

  always_comb begin
    state_nx   = state;
    ra         = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nx = READ;
      end
      READ: begin
        ra       = cnt;
        state_nx = HOLD;
      end
      HOLD: begin
        dout_valid = 1'b1;
        dout_last  = at_last;
        if (hs) state_nx = at_last ? IDLE : READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Address counter and latched end of range
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      last_q <= '0;
    end else if ((state == IDLE) && start) begin
      cnt    <= first_addr;
      last_q <= last_addr;
    end else if (hs && !at_last) begin
      cnt    <= cnt + AW'(1);
    end
  end

  // Output word capture (READ -> HOLD boundary)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_data <= '0;
      dout_addr <= '0;
    end else if (state == READ) begin
      dout_data <= cap_data;
      dout_addr <= cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= hs && at_last;
  end

endmodule
